calpoc_fsm: RTL and testbench
=============================

Name: calpoc_fsm

Overview:
- Bit-serial 3-bit two-operand logic calculator controller, driven by six push-buttons.
- The user enters operand A bit by bit, selects OR or XOR, enters operand B, then presses Equals.
- Operands drive two 3-LED banks; the result drives a 3-bit display code.
- Sits between board button inputs and LED/seven-segment output drivers.

Parameters:
- WIDTH, 3, operand/result width in bits. Ports below are sized WIDTH and are 3 at the default.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  synchronous active-high reset
- ButtonFor1  input  1  enter digit 1
- ButtonFor0  input  1  enter digit 0
- ButtonForOR  input  1  select OR operator
- ButtonForXOR  input  1  select XOR operator
- ButtonForEquals  input  1  compute result
- ButtonForClear  input  1  clear calculator
- LEDForA  output  3  current operand A register
- LEDForB  output  3  current operand B register
- SevenSeg  output  3  result register (binary value)

Behaviour:
- Clock and reset: single clock domain; all state changes on the CLK rising edge. RST is synchronous active-high.
- Reset values:
  - state = STATE_ARG1
  - A = 0, B = 0, op = OR, SevenSeg = 0
  - LEDForA = 0, LEDForB = 0
- Edge detection:
  - Each button has a "previous" flop. A press event is button=1 while prev=0, sampled at the rising edge.
  - Prev flops load the raw button values every cycle, including during RST. A button held through reset therefore creates no event afterwards.
  - A button held for many cycles produces exactly one event.
- Latency: an event is acted on at the same edge that first samples the button high. Outputs are registered and show the new value immediately after that edge.
- Priority when several events occur in one cycle: RST > Clear > Equals > OR > XOR > digit 1 > digit 0. Only the highest-priority event is acted on; the rest are discarded.
- Clear event, any state:
  - A, B and SevenSeg go to 0; op goes to OR; state goes to STATE_ARG1.
- STATE_ARG1:
  - Digit event: A <= {A[1:0], digit}, i.e. shift left with MSB first. A fourth digit shifts out the oldest bit, so A always holds the last 3 digits entered.
  - OR/XOR event: op latched; state goes to STATE_ARG2.
  - Equals: ignored.
- STATE_ARG2:
  - Digit event: B <= {B[1:0], digit}.
  - OR/XOR event: re-latches op (the last operator pressed wins).
  - Equals event: SevenSeg <= (op==OR) ? A|B : A^B; state goes to STATE_RESULT.
  - B need not contain 3 digits; unentered bits stay 0.
- STATE_RESULT:
  - Digits, operators and Equals are ignored.
  - A, B and SevenSeg hold until Clear or RST.
- Output timing: LEDForA and LEDForB reflect the A and B registers at all times. SevenSeg stays 0 until the first Equals after a clear or reset.
- No internal storage other than A, B, op, SevenSeg, state and the six prev flops.

Test Plan:
- Reset, then sequence 1,0,1,OR,0,0,1,Equals (each a 1-cycle pulse):
  - LEDForA = 3'b101 after the 3rd digit.
  - LEDForB = 3'b001 after the 7th press.
  - SevenSeg = 3'b101 the cycle after Equals.
  - Then Clear: all outputs 0.
- Reset, then 1,1,0,XOR,0,1,1,Equals -> SevenSeg = 3'b101 (110^011); LEDForA = 110; LEDForB = 011.
- Overflow and ignored inputs:
  - Digits 1,0,0,1 in ARG1 -> LEDForA = 3'b001 (oldest bit dropped).
  - Equals pressed in ARG1 -> no change; SevenSeg stays 0.
- Held button and simultaneous events:
  - ButtonFor1 held high for 5 cycles -> A shifts once only.
  - Clear and ButtonFor1 pulsed in the same cycle -> Clear wins; all outputs 0.
- In STATE_RESULT, digits and operators are ignored and outputs hold.
- Reset during STATE_ARG2 with B = 3'b010:
  - All outputs 0 the next cycle; state returns to ARG1.
  - A button held high through RST deassertion produces no event.

Source files
------------

// File: rtl/calpoc_fsm.sv
// calpoc_fsm: controller for a bit-serial two-operand logic calculator.
// Six push-buttons feed this block. The user enters operand A one bit at a time,
// picks OR or XOR, enters operand B, then presses Equals.
// Operands drive two LED banks, and the result drives a binary display code.
// Every output comes straight from a register.
module calpoc_fsm #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ButtonFor1,
    input  logic             ButtonFor0,
    input  logic             ButtonForOR,
    input  logic             ButtonForXOR,
    input  logic             ButtonForEquals,
    input  logic             ButtonForClear,
    output logic [WIDTH-1:0] LEDForA,
    output logic [WIDTH-1:0] LEDForB,
    output logic [WIDTH-1:0] SevenSeg
);

    // Controller states: collecting A, collecting B, showing the result
    typedef enum logic [1:0] {
        STATE_ARG1   = 2'd0,
        STATE_ARG2   = 2'd1,
        STATE_RESULT = 2'd2
    } state_t;

    // Latched operator
    typedef enum logic {
        OP_OR  = 1'b0,
        OP_XOR = 1'b1
    } op_t;

    // At most one event is acted on per cycle; this is the winner after priority
    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_CLEAR  = 3'd1,
        EV_EQUALS = 3'd2,
        EV_OR     = 3'd3,
        EV_XOR    = 3'd4,
        EV_ONE    = 3'd5,
        EV_ZERO   = 3'd6
    } event_t;

    // Shift a new digit into the LSB, MSB first; the oldest bit falls off the top
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] val,
        input logic             digit
    );
        shift_in = {val[WIDTH-2:0], digit};
    endfunction

    // Apply the latched operator to both operands
    function automatic logic [WIDTH-1:0] compute_result(
        input op_t              op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = {WIDTH{1'b0}};
        endcase
        compute_result = res;
    endfunction

    // Registers
    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_seg;

    logic             r_prev_1;
    logic             r_prev_0;
    logic             r_prev_or;
    logic             r_prev_xor;
    logic             r_prev_eq;
    logic             r_prev_clr;

    // Combinational signals
    logic             w_ev_1;
    logic             w_ev_0;
    logic             w_ev_or;
    logic             w_ev_xor;
    logic             w_ev_eq;
    logic             w_ev_clr;
    event_t           w_event;

    state_t           w_state_nxt;
    op_t              w_op_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_seg_nxt;

    // Previous-value flops load every cycle, including during RST, so a button
    // held through reset does not look like a fresh press afterwards
    always_ff @(posedge CLK) begin
        r_prev_1   <= ButtonFor1;
        r_prev_0   <= ButtonFor0;
        r_prev_or  <= ButtonForOR;
        r_prev_xor <= ButtonForXOR;
        r_prev_eq  <= ButtonForEquals;
        r_prev_clr <= ButtonForClear;
    end

    // A press event is a rising edge: the button is high now and was low last cycle
    assign w_ev_1   = ButtonFor1      & ~r_prev_1;
    assign w_ev_0   = ButtonFor0      & ~r_prev_0;
    assign w_ev_or  = ButtonForOR     & ~r_prev_or;
    assign w_ev_xor = ButtonForXOR    & ~r_prev_xor;
    assign w_ev_eq  = ButtonForEquals & ~r_prev_eq;
    assign w_ev_clr = ButtonForClear  & ~r_prev_clr;

    // Priority-select a single event: Clear > Equals > OR > XOR > 1 > 0
    always_comb begin
        w_event = EV_NONE;
        if (w_ev_clr) begin
            w_event = EV_CLEAR;
        end else if (w_ev_eq) begin
            w_event = EV_EQUALS;
        end else if (w_ev_or) begin
            w_event = EV_OR;
        end else if (w_ev_xor) begin
            w_event = EV_XOR;
        end else if (w_ev_1) begin
            w_event = EV_ONE;
        end else if (w_ev_0) begin
            w_event = EV_ZERO;
        end else begin
            w_event = EV_NONE;
        end
    end

    // Next-state and next-datapath decode for the selected event
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_seg_nxt   = r_seg;

        if (w_event == EV_CLEAR) begin
            w_state_nxt = STATE_ARG1;
            w_op_nxt    = OP_OR;
            w_a_nxt     = {WIDTH{1'b0}};
            w_b_nxt     = {WIDTH{1'b0}};
            w_seg_nxt   = {WIDTH{1'b0}};
        end else begin
            case (r_state)
                STATE_ARG1: begin
                    case (w_event)
                        EV_ONE:  w_a_nxt = shift_in(r_a, 1'b1);
                        EV_ZERO: w_a_nxt = shift_in(r_a, 1'b0);
                        EV_OR: begin
                            w_op_nxt    = OP_OR;
                            w_state_nxt = STATE_ARG2;
                        end
                        EV_XOR: begin
                            w_op_nxt    = OP_XOR;
                            w_state_nxt = STATE_ARG2;
                        end
                        // Equals has nothing to compute yet
                        default: w_state_nxt = STATE_ARG1;
                    endcase
                end
                STATE_ARG2: begin
                    case (w_event)
                        EV_ONE:  w_b_nxt = shift_in(r_b, 1'b1);
                        EV_ZERO: w_b_nxt = shift_in(r_b, 1'b0);
                        // The last operator pressed before Equals wins
                        EV_OR:   w_op_nxt = OP_OR;
                        EV_XOR:  w_op_nxt = OP_XOR;
                        EV_EQUALS: begin
                            w_seg_nxt   = compute_result(r_op, r_a, r_b);
                            w_state_nxt = STATE_RESULT;
                        end
                        default: w_state_nxt = STATE_ARG2;
                    endcase
                end
                // Result is frozen; only Clear or RST leave this state
                STATE_RESULT: w_state_nxt = STATE_RESULT;
                // An illegal encoding recovers to a clean start
                default: begin
                    w_state_nxt = STATE_ARG1;
                    w_op_nxt    = OP_OR;
                    w_a_nxt     = {WIDTH{1'b0}};
                    w_b_nxt     = {WIDTH{1'b0}};
                    w_seg_nxt   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= STATE_ARG1;
            r_op    <= OP_OR;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_seg   <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign LEDForA  = r_a;
    assign LEDForB  = r_b;
    assign SevenSeg = r_seg;

endmodule

// File: tb/tb_calpoc_fsm.sv
// Testbench for calpoc_fsm. It runs directed sequences and then random button
// traffic. After every clock edge, all outputs are compared with a behavioural
// model of the calculator.
module tb_calpoc_fsm;

    // Button vector layout used by the bench: bit index doubles as priority rank
    localparam logic [5:0] B_ZERO  = 6'b000001;
    localparam logic [5:0] B_ONE   = 6'b000010;
    localparam logic [5:0] B_XOR   = 6'b000100;
    localparam logic [5:0] B_OR    = 6'b001000;
    localparam logic [5:0] B_EQ    = 6'b010000;
    localparam logic [5:0] B_CLR   = 6'b100000;
    localparam logic [5:0] B_NONE  = 6'b000000;

    logic       CLK;
    logic       RST;
    logic [5:0] btn;
    logic [2:0] LEDForA;
    logic [2:0] LEDForB;
    logic [2:0] SevenSeg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 = entering A, 1 = entering B, 2 = showing the result
    int         m_state = 0;
    int         m_a     = 0;
    int         m_b     = 0;
    int         m_seg   = 0;
    bit         m_xor   = 1'b0;
    logic [5:0] m_prev  = 6'b000000;

    calpoc_fsm #(.WIDTH(3)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ButtonFor1      (btn[1]),
        .ButtonFor0      (btn[0]),
        .ButtonForOR     (btn[3]),
        .ButtonForXOR    (btn[2]),
        .ButtonForEquals (btn[4]),
        .ButtonForClear  (btn[5]),
        .LEDForA         (LEDForA),
        .LEDForB         (LEDForB),
        .SevenSeg        (SevenSeg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Calculator behaviour: rising edges become presses, the highest-ranked press wins
    task automatic model_update(input logic [5:0] b, input logic rst);
        logic [5:0] ev;
        int top;
        ev     = b & ~m_prev;
        m_prev = b;
        top    = -1;
        for (int i = 5; i >= 0; i--) begin
            if (ev[i] && top < 0) top = i;
        end
        if (rst) begin
            m_state = 0; m_a = 0; m_b = 0; m_seg = 0; m_xor = 1'b0;
        end else if (top == 5) begin
            m_state = 0; m_a = 0; m_b = 0; m_seg = 0; m_xor = 1'b0;
        end else if (top == 4) begin
            if (m_state == 1) begin
                m_seg   = m_xor ? (m_a ^ m_b) : (m_a | m_b);
                m_state = 2;
            end
        end else if (top == 3 || top == 2) begin
            if (m_state == 0 || m_state == 1) begin
                m_xor   = (top == 2);
                m_state = 1;
            end
        end else if (top == 1 || top == 0) begin
            // top is the digit value itself (bit 1 = digit 1, bit 0 = digit 0)
            if (m_state == 0) m_a = (m_a * 2 + top) % 8;
            else if (m_state == 1) m_b = (m_b * 2 + top) % 8;
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare after it
    task automatic step(input logic [5:0] b, input logic rst);
        @(negedge CLK);
        btn = b;
        RST = rst;
        @(posedge CLK);
        model_update(b, rst);
        #1;
        check_val("LEDForA",  {5'b00000, LEDForA},  8'(m_a));
        check_val("LEDForB",  {5'b00000, LEDForB},  8'(m_b));
        check_val("SevenSeg", {5'b00000, SevenSeg}, 8'(m_seg));
    endtask

    // A single-cycle press followed by release
    task automatic press(input logic [5:0] b);
        step(b, 1'b0);
        step(B_NONE, 1'b0);
    endtask

    initial begin
        btn = B_NONE;
        RST = 1'b1;

        // Reset state
        step(B_NONE, 1'b1);
        step(B_NONE, 1'b1);
        check_val("rst_A",   {5'b0, LEDForA},  8'd0);
        check_val("rst_seg", {5'b0, SevenSeg}, 8'd0);

        // 1,0,1,OR,0,0,1,Equals -> 101 | 001 = 101
        step(B_NONE, 1'b0);
        press(B_ONE); press(B_ZERO); press(B_ONE);
        check_val("seq1_A", {5'b0, LEDForA}, 8'd5);
        press(B_OR); press(B_ZERO); press(B_ZERO); press(B_ONE);
        check_val("seq1_B", {5'b0, LEDForB}, 8'd1);
        step(B_EQ, 1'b0);
        check_val("seq1_seg", {5'b0, SevenSeg}, 8'd5);
        step(B_NONE, 1'b0);
        press(B_CLR);
        check_val("clr_A",   {5'b0, LEDForA},  8'd0);
        check_val("clr_B",   {5'b0, LEDForB},  8'd0);
        check_val("clr_seg", {5'b0, SevenSeg}, 8'd0);

        // 1,1,0,XOR,0,1,1,Equals -> 110 ^ 011 = 101
        step(B_NONE, 1'b1);
        step(B_NONE, 1'b0);
        press(B_ONE); press(B_ONE); press(B_ZERO); press(B_XOR);
        press(B_ZERO); press(B_ONE); press(B_ONE); press(B_EQ);
        check_val("seq2_seg", {5'b0, SevenSeg}, 8'd5);
        check_val("seq2_A",   {5'b0, LEDForA},  8'd6);
        check_val("seq2_B",   {5'b0, LEDForB},  8'd3);

        // In the result state, digits, operators and Equals are ignored
        press(B_ONE); press(B_ZERO); press(B_OR); press(B_XOR); press(B_EQ);
        check_val("hold_seg", {5'b0, SevenSeg}, 8'd5);
        check_val("hold_A",   {5'b0, LEDForA},  8'd6);
        check_val("hold_B",   {5'b0, LEDForB},  8'd3);

        // Four digits keep only the last three; Equals while entering A does nothing
        step(B_NONE, 1'b1);
        step(B_NONE, 1'b0);
        press(B_ONE); press(B_ZERO); press(B_ZERO); press(B_ONE);
        check_val("ovf_A", {5'b0, LEDForA}, 8'd1);
        press(B_EQ);
        check_val("eq_arg1_seg", {5'b0, SevenSeg}, 8'd0);
        check_val("eq_arg1_A",   {5'b0, LEDForA},  8'd1);

        // A held digit shifts only once
        press(B_CLR);
        for (int i = 0; i < 5; i++) step(B_ONE, 1'b0);
        check_val("held_A", {5'b0, LEDForA}, 8'd1);
        step(B_NONE, 1'b0);

        // Clear beats a simultaneous digit
        press(B_ONE);
        step(B_CLR | B_ONE, 1'b0);
        check_val("simul_A", {5'b0, LEDForA}, 8'd0);
        step(B_NONE, 1'b0);

        // Reset in ARG2 with B = 010, with digit 1 held through the release of RST
        press(B_ONE); press(B_OR); press(B_ONE); press(B_ZERO);
        check_val("arg2_B", {5'b0, LEDForB}, 8'd2);
        step(B_ONE, 1'b1);
        check_val("rst2_A", {5'b0, LEDForA}, 8'd0);
        check_val("rst2_B", {5'b0, LEDForB}, 8'd0);
        step(B_ONE, 1'b0);
        step(B_ONE, 1'b0);
        check_val("rst2_noev_A", {5'b0, LEDForA}, 8'd0);
        step(B_NONE, 1'b0);
        // The controller is back in ARG1: a digit lands in A, not B
        press(B_ONE);
        check_val("rst2_arg1_A", {5'b0, LEDForA}, 8'd1);
        check_val("rst2_arg1_B", {5'b0, LEDForB}, 8'd0);

        // Random button traffic compared with the model every cycle
        for (int n = 0; n < 2000; n++) begin
            logic [5:0] b;
            logic       r;
            b[0] = ($urandom_range(0, 3) == 0);
            b[1] = ($urandom_range(0, 3) == 0);
            b[2] = ($urandom_range(0, 7) == 0);
            b[3] = ($urandom_range(0, 7) == 0);
            b[4] = ($urandom_range(0, 7) == 0);
            b[5] = ($urandom_range(0, 39) == 0);
            r    = ($urandom_range(0, 99) == 0);
            step(b, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
